// File: rtl/acc_ready_dispatcher_pkg.sv
// Shared definitions for the ready-queue task dispatcher: FSM state
// encoding and helpers that derive slot and index widths from parameters.
package acc_ready_dispatcher_pkg;

  // Dispatcher control states: waiting for work, or streaming one slot.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Words in one task slot: tid, twid, then the argument words.
  function automatic int slot_size(input int nargs);
    return nargs + 2;
  endfunction

  // Width of an index into an n-entry vector (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_ready_dispatcher_rr_arbiter.sv
// Round-robin requester selection: picks the first asserted request at or
// after ptr_i, wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter
  import acc_ready_dispatcher_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Candidate index for each search offset, and whether it is requesting.
  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_off
    logic [IW:0] sum;
    assign sum       = {1'b0, ptr_i} + (IW+1)'(gi);
    assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign hit[gi]   = req_i[cand[gi]];
  end

  // Lowest search offset with an active request wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && hit[k]) begin
        any_o = 1'b1;
        idx_o = cand[k];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_oh
    assign grant_o[gi] = any_o && (idx_o == IW'(gi));
  end

endmodule

// File: rtl/acc_ready_dispatcher.sv
// Pulls complete task slots from a ready queue and streams them, one word
// at a time, to a round-robin selected idle accelerator. One queue read is
// outstanding at a time, giving one word every two cycles.
module acc_ready_dispatcher
  import acc_ready_dispatcher_pkg::*;
#(
  parameter int NARGS = 1,
  parameter int NACC  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_empty,
  output logic            q_read,
  input  logic [63:0]     q_dout,
  input  logic [NACC-1:0] acc_req,
  output logic [NACC-1:0] acc_valid,
  output logic [63:0]     acc_data,
  output logic            acc_last,
  input  logic [NACC-1:0] acc_ready,
  output logic            busy
);

  localparam int SLOT_SIZE = slot_size(NARGS);
  localparam int WW        = $clog2(SLOT_SIZE + 1);
  localparam int IW        = idx_width(NACC);

  localparam logic [WW-1:0] SLOT_W   = WW'(SLOT_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NACC - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [NACC-1:0] grant_oh_q, grant_oh_d;
  logic [WW-1:0]   words_q, words_d;
  logic            inflight_q, inflight_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     data_q, data_d;
  logic            last_q, last_d;

  logic [NACC-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            fire;

  rr_arbiter #(
    .N  (NACC),
    .IW (IW)
  ) u_arb (
    .req_i   (acc_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Only the granted accelerator's ready can consume the held word.
  assign fire = out_valid_q && |(grant_oh_q & acc_ready);

  // Next-state logic: slot start, paced queue reads, output hand-off.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    words_d     = words_q;
    inflight_d  = 1'b0;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    last_d      = last_q;
    q_read      = 1'b0;

    case (state_q)
      IDLE: begin
        // A non-empty queue means a whole slot is available to stream.
        if (!q_empty && arb_any) begin
          state_d    = XFER;
          grant_d    = arb_idx;
          grant_oh_d = arb_grant;
          words_d    = '0;
        end
      end

      XFER: begin
        // Fetch the next word only once the output register is free (or
        // being freed this cycle) and no read is still in flight.
        q_read = (words_q < SLOT_W) && !inflight_q && (!out_valid_q || fire);

        if (inflight_q) begin
          // Word requested last cycle is on q_dout now.
          out_valid_d = 1'b1;
          data_d      = q_dout;
          last_d      = (words_q == SLOT_W);
        end else if (fire) begin
          out_valid_d = 1'b0;
          if (last_q) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IW'(1);
          end
        end

        inflight_d = q_read;
        if (q_read) begin
          words_d = words_q + WW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      words_q     <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      words_q     <= words_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign acc_valid = out_valid_q ? grant_oh_q : '0;
  assign acc_data  = data_q;
  assign acc_last  = out_valid_q && last_q;
  assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_acc_ready_dispatcher.sv
// Bench for acc_ready_dispatcher: a word-queue environment plus a
// cycle-level reference model of the dispatch rules, followed by directed
// scenarios pinned with literal expectations and a randomized run.
module tb_acc_ready_dispatcher;

  localparam int NARGS = 1;
  localparam int NACC  = 2;
  localparam int SLOT  = NARGS + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            q_empty;
  logic            q_read;
  logic [63:0]     q_dout;
  logic [NACC-1:0] acc_req;
  logic [NACC-1:0] acc_valid;
  logic [63:0]     acc_data;
  logic            acc_last;
  logic [NACC-1:0] acc_ready;
  logic            busy;

  acc_ready_dispatcher #(
    .NARGS (NARGS),
    .NACC  (NACC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q_empty   (q_empty),
    .q_read    (q_read),
    .q_dout    (q_dout),
    .acc_req   (acc_req),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_last  (acc_last),
    .acc_ready (acc_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Hardware queue contents and the model's copy of the same word stream.
  logic [63:0] qw[$];
  logic [63:0] mq[$];
  bit          rd_seen;

  // Sampled DUT outputs of the current cycle.
  logic            s_qread, s_last, s_busy, prev_busy;
  logic [NACC-1:0] s_valid;
  logic [63:0]     s_data;
  int              enter_cyc;

  // Log of observed hand-offs.
  logic [63:0] f_word[$];
  int          f_acc[$];
  int          f_cyc[$];
  bit          f_last[$];
  int          qr_count;

  // Reference model state.
  bit          m_busy, m_have, m_arr;
  int          m_grant, m_ptr, m_fetched, m_idx;
  logic [63:0] m_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_have = 0; m_arr = 0;
    m_grant = 0; m_ptr = 0; m_fetched = 0; m_idx = 0;
    m_word = '0;
  endtask

  task automatic push3(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
    qw.push_back(w0); qw.push_back(w1); qw.push_back(w2);
    mq.push_back(w0); mq.push_back(w1); mq.push_back(w2);
  endtask

  task automatic clear_logs();
    f_word.delete(); f_acc.delete(); f_cyc.delete(); f_last.delete();
    qr_count = 0;
  endtask

  function automatic logic [63:0] fw(input int i);
    return (i < f_word.size()) ? f_word[i] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic int fa(input int i);
    return (i < f_acc.size()) ? f_acc[i] : -1;
  endfunction

  function automatic int fc(input int i);
    return (i < f_cyc.size()) ? f_cyc[i] : -100;
  endfunction

  // One clock cycle: serve the queue, drive inputs, sample, compare, advance model.
  task automatic step(input logic [NACC-1:0] req, input logic [NACC-1:0] rdy, input logic r);
    logic [NACC-1:0] e_valid;
    bit              e_last, e_fire, e_qread, found;
    int              c, who;
    @(posedge clk);
    #1;
    if (!rst && rd_seen) q_dout = (qw.size() > 0) ? qw.pop_front() : 64'h0;
    else q_dout = {$urandom, $urandom};
    rst       = r;
    acc_req   = req;
    acc_ready = rdy;
    q_empty   = (qw.size() < SLOT);
    @(negedge clk);
    cyc++;
    s_qread = q_read; s_valid = acc_valid; s_data = acc_data;
    s_last  = acc_last; s_busy = busy;
    if (s_busy && !prev_busy) enter_cyc = cyc;
    prev_busy = s_busy;

    e_valid = '0;
    if (m_have) e_valid[m_grant] = 1'b1;
    e_last  = m_have && (m_idx == SLOT - 1);
    e_fire  = m_have && rdy[m_grant];
    e_qread = m_busy && (m_fetched < SLOT) && !m_arr && (!m_have || e_fire);
    chk("q_read", s_qread, e_qread);
    chk("acc_valid", s_valid, e_valid);
    chk("acc_last", s_last, e_last);
    chk("busy", s_busy, m_busy);
    if (m_have) chk("acc_data", s_data, m_word);

    if (s_qread) qr_count++;
    if (|(s_valid & rdy)) begin
      who = -1;
      for (int k = 0; k < NACC; k++) if (s_valid[k] && rdy[k]) who = k;
      f_word.push_back(s_data); f_acc.push_back(who);
      f_cyc.push_back(cyc);     f_last.push_back(s_last);
      $display("cyc=%0d fire acc=%0d word=%0h last=%0b", cyc, who, s_data, s_last);
    end
    rd_seen = s_qread;

    if (r) begin
      model_reset();
      qw.delete();
      mq.delete();
    end else if (!m_busy) begin
      if (mq.size() >= SLOT && |req) begin
        found = 0;
        for (int k = 0; k < NACC; k++) begin
          c = (m_ptr + k) % NACC;
          if (!found && req[c]) begin found = 1; m_grant = c; end
        end
        m_busy = 1; m_fetched = 0; m_have = 0; m_arr = 0;
      end
    end else begin
      if (m_arr) begin
        m_have = 1;
        m_word = (mq.size() > 0) ? mq.pop_front() : 64'h0;
        m_idx  = m_fetched - 1;
      end else if (e_fire) begin
        m_have = 0;
        if (e_last) begin
          m_busy = 0;
          m_ptr  = (m_grant + 1) % NACC;
        end
      end
      m_arr = e_qread;
      if (e_qread) m_fetched++;
    end
  endtask

  task automatic do_reset();
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    clear_logs();
  endtask

  task automatic run_fires(input int n, input logic [NACC-1:0] req,
                           input logic [NACC-1:0] rdy, input int maxc);
    int k;
    k = 0;
    while (f_word.size() < n && k < maxc) begin
      step(req, rdy, 1'b0);
      k++;
    end
    chk("fire_count_within_budget", f_word.size(), n);
  endtask

  initial begin
    int k;
    logic [NACC-1:0] rq, rd;
    rst = 1'b1; q_empty = 1'b1; q_dout = '0; acc_req = '0; acc_ready = '0;
    rd_seen = 0; prev_busy = 0; enter_cyc = 0; qr_count = 0;
    model_reset();

    // Reset state.
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    chk("rst_acc_data", s_data, 64'h0);
    chk("rst_acc_valid", s_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_q_read", s_qread, 0);
    chk("rst_acc_last", s_last, 0);

    // Single slot to accelerator 0 at two-cycle spacing.
    clear_logs();
    push3(64'h11, 64'h22, 64'h33);
    run_fires(3, 2'b01, 2'b01, 40);
    chk("a_w0", fw(0), 64'h11);
    chk("a_w1", fw(1), 64'h22);
    chk("a_w2", fw(2), 64'h33);
    chk("a_acc0", fa(0), 0);
    chk("a_acc2", fa(2), 0);
    chk("a_first_latency", fc(0) - enter_cyc, 2);
    chk("a_spacing01", fc(1) - fc(0), 2);
    chk("a_spacing12", fc(2) - fc(1), 2);
    chk("a_last_only_end", {f_last.size() > 2 ? f_last[2] : 1'b0, f_last.size() > 0 ? f_last[0] : 1'b1}, 2'b10);
    chk("a_q_reads", qr_count, 3);
    chk("a_model_rr_ptr", m_ptr, 1);
    // rr_ptr now 1: with both requesting, accelerator 1 wins.
    clear_logs();
    push3(64'h44, 64'h55, 64'h66);
    run_fires(3, 2'b11, 2'b11, 40);
    chk("a_next_grant_acc1", fa(0), 1);

    // Two slots, both requesting: alternate grants, six reads total.
    do_reset();
    push3(64'hA0, 64'hA1, 64'hA2);
    push3(64'hB0, 64'hB1, 64'hB2);
    run_fires(6, 2'b11, 2'b11, 80);
    for (int i = 0; i < 5; i++) step(2'b11, 2'b11, 1'b0);
    chk("b_slot1_acc", fa(0), 0);
    chk("b_slot1_last_acc", fa(2), 0);
    chk("b_slot2_acc", fa(3), 1);
    chk("b_slot2_last_acc", fa(5), 1);
    chk("b_slot2_w0", fw(3), 64'hB0);
    chk("b_q_reads", qr_count, 6);

    // Stall on word 1 for five cycles.
    do_reset();
    push3(64'h11, 64'h22, 64'h33);
    run_fires(1, 2'b01, 2'b01, 40);
    k = 0;
    do begin
      step(2'b01, 2'b00, 1'b0);
      k++;
    end while (s_valid == '0 && k < 10);
    chk("c_word1_arrived", s_valid, 2'b01);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 2'b00, 1'b0);
      chk("c_stall_data", s_data, 64'h22);
      chk("c_stall_no_read", s_qread, 0);
    end
    run_fires(3, 2'b01, 2'b01, 40);
    chk("c_w0", fw(0), 64'h11);
    chk("c_w1", fw(1), 64'h22);
    chk("c_w2", fw(2), 64'h33);
    chk("c_q_reads", qr_count, 3);

    // Empty queue with requests: nothing happens.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 2'b11, 1'b0);
      chk("d_no_read", s_qread, 0);
      chk("d_not_busy", s_busy, 0);
    end

    // Reset one cycle after the second word fires.
    do_reset();
    push3(64'h71, 64'h72, 64'h73);
    run_fires(2, 2'b01, 2'b01, 40);
    step(2'b01, 2'b01, 1'b1);
    step(2'b01, 2'b01, 1'b0);
    chk("e_valid", s_valid, 0);
    chk("e_data", s_data, 64'h0);
    chk("e_last", s_last, 0);
    chk("e_busy", s_busy, 0);
    chk("e_q_read", s_qread, 0);
    chk("e_model_rr_ptr", m_ptr, 0);
    clear_logs();
    push3(64'h81, 64'h82, 64'h83);
    run_fires(3, 2'b11, 2'b11, 40);
    chk("e_grant_after_rst", fa(0), 0);

    // Granted requester drops mid-slot; other one is ready but ignored.
    do_reset();
    push3(64'h91, 64'h92, 64'h93);
    k = 0;
    do begin
      step(2'b01, 2'b00, 1'b0);
      k++;
    end while (!s_busy && k < 10);
    run_fires(3, 2'b10, 2'b11, 40);
    chk("f_acc0", fa(0), 0);
    chk("f_acc1", fa(1), 0);
    chk("f_acc2", fa(2), 0);
    chk("f_w2", fw(2), 64'h93);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0 && qw.size() < 4 * SLOT)
        push3({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      rq = NACC'($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) == 0) ? '0 : NACC'($urandom_range(0, 3));
      step(rq, rd, ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_ready_dispatcher.md
ACC_READY_DISPATCHER -- requirements
Module: acc_ready_dispatcher

Interface
REQ-001 SHALL have parameter NARGS, default 1: argument words per task slot (slot = tid, twid, NARGS args; SLOT_SIZE = NARGS+2).
REQ-002 SHALL have parameter NACC, default 2: number of accelerator requesters, range 1..16.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port q_empty  input  1  ready queue holds no complete slot.
REQ-006 SHALL have port q_read  output  1  pop one 64-bit word from ready queue.
REQ-007 SHALL have port q_dout  input  64  queue word, valid the cycle after q_read.
REQ-008 SHALL have port acc_req  input  NACC  accelerator i idle and requesting a task.
REQ-009 SHALL have port acc_valid  output  NACC  one-hot word-valid to the granted accelerator.
REQ-010 SHALL have port acc_data  output  64  task word (shared bus).
REQ-011 SHALL have port acc_last  output  1  current word is last word of slot.
REQ-012 SHALL have port acc_ready  input  NACC  accelerator i accepts the word.
REQ-013 SHALL have port busy  output  1  high while in XFER state.

Function
REQ-014 SHALL implement FSM states IDLE and XFER.
REQ-015 IDLE -> XFER SHALL occur when !q_empty && |acc_req; grant index latched that cycle by round-robin from rr_ptr (first requester at or after rr_ptr, wrapping at NACC-1 -> 0).
REQ-016 q_read SHALL never assert in IDLE; q_empty SHALL be ignored in XFER (a non-empty queue guarantees a complete slot).
REQ-017 In XFER, q_read SHALL assert when words_issued < SLOT_SIZE && !inflight && (!out_valid || fire), where fire = out_valid && acc_ready[grant].
REQ-018 inflight SHALL set on q_read and clear the next cycle; q_dout SHALL load the output register that cycle, setting out_valid.
REQ-019 Sustained throughput SHALL be one word per two cycles; first word SHALL be valid 2 cycles after entering XFER.
REQ-020 acc_valid SHALL equal out_valid ? (1 << grant) : 0; acc_data/acc_last SHALL hold stable while valid and not fired.
REQ-021 Word order SHALL be tid, twid, arg0..arg(NARGS-1); acc_last SHALL be high only on word SLOT_SIZE-1.
REQ-022 words_issued SHALL be $clog2(SLOT_SIZE+1) bits, increment per q_read, clear on entering XFER.
REQ-023 On fire with acc_last: SHALL return to IDLE, set rr_ptr = grant+1 (wrap to 0 after NACC-1), out_valid clears.
REQ-024 Deassertion of acc_req[grant] during XFER SHALL NOT abort the transfer; other requests SHALL be ignored until IDLE.
REQ-025 A new grant SHALL be possible the cycle after the last-word fire (no back-to-back in the same cycle).
REQ-026 acc_ready of non-granted accelerators SHALL have no effect.

Reset
REQ-027 On rst: state=IDLE, rr_ptr=0, grant=0, words_issued=0, inflight=0, out_valid=0; q_read, acc_valid, acc_last, busy = 0; acc_data = 0.
REQ-028 rst mid-XFER SHALL abort the slot with no further q_read; queue is reset by the same rst.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (IDLE, XFER) and SLOT_SIZE derivation function.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, pointer in; one-hot grant, index, any out).

Verification
REQ-031 NARGS=1, NACC=2, queue holds slot {0x11,0x22,0x33}, acc_req=01, acc_ready=1 -> acc_valid=01 with 0x11,0x22,0x33 at 2-cycle spacing, acc_last on 0x33, rr_ptr=1.
REQ-032 Two slots queued, acc_req=11 held -> slot 1 to acc0, slot 2 to acc1; exactly 6 q_read pulses total.
REQ-033 acc_ready[grant]=0 for 5 cycles on word 1 -> acc_data holds 0x22 stable, no q_read during stall, no word lost or duplicated.
REQ-034 q_empty=1, acc_req=11 for 20 cycles -> q_read=0, busy=0 throughout.
REQ-035 rst asserted one cycle after second word fires -> next cycle all outputs 0, state IDLE, rr_ptr=0.
REQ-036 acc_req[grant] dropped mid-slot and acc_ready[other]=1 -> transfer completes to original grant only.
